// File: rtl/rf_tx_burst_buffer_if.sv
// ---------------------------------------------------------------------------
// rf_tx_burst_buffer_if
// Handshake and status bundle between the MCU-side writer / node-side reader
// and the rf_tx_burst_buffer staging FIFO.
//
// Signals:
//   in_data   - write word from the MCU-side UART
//   in_valid  - one-cycle write strobe
//   flush     - pulse that forces a pending partial frame out
//   out_data  - head word (first-word fall-through)
//   out_valid - head word may be drained
//   out_ready - consumer takes the head word this cycle
//   level     - current occupancy
//   full      - occupancy equals DEPTH
//   overflow  - sticky: a write was dropped
//   ovf_clr   - clears overflow
//   aux       - 1 = idle (empty and settled), 0 = busy
//
// Modports: master = writer/reader side, slave = buffer side.
// ---------------------------------------------------------------------------
interface rf_tx_burst_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 512
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  flush;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [LW-1:0]         level;
    logic                  full;
    logic                  overflow;
    logic                  ovf_clr;
    logic                  aux;

    modport master (
        output in_data, in_valid, flush, out_ready, ovf_clr,
        input  out_data, out_valid, level, full, overflow, aux
    );

    modport slave (
        input  in_data, in_valid, flush, out_ready, ovf_clr,
        output out_data, out_valid, level, full, overflow, aux
    );
endinterface

// File: rtl/rf_tx_burst_buffer.sv
// ---------------------------------------------------------------------------
// rf_tx_burst_buffer
// Stages bytes from the MCU-side UART in a circular FIFO and releases them to
// the node-side UART as one burst. A burst starts when the occupancy reaches
// START_LEVEL, on a flush pulse, or (optionally) after IDLE_TIMEOUT cycles
// without a write. After the FIFO drains, aux stays low for SETTLE_CYCLES
// before signalling idle again.
//
// Optional feature macro: RF_BUF_TIMEOUT_FLUSH_EN
//   defined   - the write-idle timeout also starts a burst
//   undefined - no idle counter; a partial frame waits for threshold or flush
//
// Ports:
//   internal_clk - sole clock, rising edge
//   rst          - asynchronous, active-high reset
//   bus          - rf_tx_burst_buffer_if.slave (data, handshake, status)
// ---------------------------------------------------------------------------
module rf_tx_burst_buffer #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 512,
    parameter int START_LEVEL   = 58,
    parameter int IDLE_TIMEOUT  = 26041,
    parameter int SETTLE_CYCLES = 125000
) (
    input  logic                 internal_clk,
    input  logic                 rst,
    rf_tx_burst_buffer_if.slave  bus
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_BURST, ST_SETTLE} state_t;

    state_t                r_state;
    logic                  r_aux;
    logic                  r_out_valid;
    logic [LW-1:0]         r_level;
    logic                  r_full;
    logic                  r_ovf;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [SW-1:0]         r_settle_cnt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_pop;
    logic                  w_wr_acc;
    logic                  w_timeout;
    logic                  w_start;
    logic [LW-1:0]         w_level_nxt;

    // out_valid is a register, so the pop decision never loops back
    // combinationally from out_ready into out_valid.
    assign w_pop    = r_out_valid && bus.out_ready;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign w_wr_acc = bus.in_valid && (!r_full || w_pop);

`ifdef RF_BUF_TIMEOUT_FLUSH_EN
    localparam int IW = $clog2(IDLE_TIMEOUT);
    logic [IW-1:0] r_idle_cnt;

    assign w_timeout = !w_wr_acc && (r_idle_cnt == IW'(IDLE_TIMEOUT - 1));

    // Counts write-idle cycles only while filling; held at zero elsewhere so
    // every entry into FILL starts from a fresh count.
    always_ff @(posedge internal_clk or posedge rst) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if (r_state != ST_FILL || w_wr_acc) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_start = (r_level >= LW'(START_LEVEL)) || bus.flush || w_timeout;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_wr_acc, w_pop})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    // Storage is not reset: contents are meaningless once the pointers clear.
    always_ff @(posedge internal_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    // Control FSM with pointers, occupancy and registered status outputs.
    // aux and out_valid are computed from the next state so they line up
    // with r_state after every edge.
    always_ff @(posedge internal_clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_aux        <= 1'b1;
            r_out_valid  <= 1'b0;
            r_level      <= '0;
            r_full       <= 1'b0;
            r_ovf        <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_settle_cnt <= '0;
        end else begin
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LW'(DEPTH));
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // A dropped write in the same cycle as a clear keeps the flag set.
            if (bus.in_valid && !w_wr_acc) begin
                r_ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_ovf <= 1'b0;
            end

            r_aux        <= 1'b0;
            r_out_valid  <= 1'b0;
            r_settle_cnt <= '0;
            case (r_state)
                ST_IDLE: begin
                    r_aux <= 1'b1;
                    if (w_wr_acc) begin
                        r_state <= ST_FILL;
                        r_aux   <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (w_start) begin
                        r_state     <= ST_BURST;
                        r_out_valid <= (w_level_nxt != '0);
                    end
                end
                ST_BURST: begin
                    // Leave only once the FIFO is empty and nothing new arrives.
                    if (r_level == '0 && !w_wr_acc) begin
                        r_state <= ST_SETTLE;
                    end else begin
                        r_out_valid <= (w_level_nxt != '0);
                    end
                end
                ST_SETTLE: begin
                    if (w_wr_acc) begin
                        r_state <= ST_FILL;
                    end else if (r_settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                        r_state <= ST_IDLE;
                        r_aux   <= 1'b1;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_aux   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.out_data  = r_mem[r_rd_ptr];
    assign bus.out_valid = r_out_valid;
    assign bus.level     = r_level;
    assign bus.full      = r_full;
    assign bus.overflow  = r_ovf;
    assign bus.aux       = r_aux;
endmodule

// File: tb/tb_rf_tx_burst_buffer.sv
// ---------------------------------------------------------------------------
// tb_rf_tx_burst_buffer
// Directed scenarios followed by random traffic, every cycle compared with a
// queue-based reference model built from the buffer's behavioural rules.
// ---------------------------------------------------------------------------
module tb_rf_tx_burst_buffer;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int SL    = 4;
    localparam int TO    = 10;
    localparam int SC    = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rf_tx_burst_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus();

    rf_tx_burst_buffer #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .START_LEVEL  (SL),
        .IDLE_TIMEOUT (TO),
        .SETTLE_CYCLES(SC)
    ) dut (
        .internal_clk(clk),
        .rst         (rst),
        .bus         (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a queue for the stored words, a phase, and the edge
    // numbers of the last accepted write and of the moment draining finished.
    typedef enum {P_IDLE, P_FILL, P_BURST, P_SETTLE} phase_t;
    phase_t     ph;
    logic [7:0] q[$];
    bit         m_ovf;
    int         cyc, t_wr, t_settle;

    task automatic m_reset();
        ph = P_IDLE;
        q.delete();
        m_ovf = 1'b0;
        cyc = 0;
        t_wr = 0;
        t_settle = 0;
    endtask

    task automatic m_step(input bit v, input logic [7:0] d, input bit fl, input bit rdy, input bit clr);
        bit pop, acc, tmo;
        int n;
        cyc++;
        n   = q.size();
        pop = (ph == P_BURST) && (n != 0) && rdy;
        acc = v && ((n < DEPTH) || pop);
        tmo = 1'b0;
`ifdef RF_BUF_TIMEOUT_FLUSH_EN
        tmo = !acc && ((cyc - t_wr) >= TO);
`endif
        case (ph)
            P_IDLE:   if (acc) ph = P_FILL;
            P_FILL:   if (n >= SL || fl || tmo) ph = P_BURST;
            P_BURST:  if (n == 0 && !acc) begin ph = P_SETTLE; t_settle = cyc; end
            P_SETTLE: begin
                if (acc) ph = P_FILL;
                else if ((cyc - t_settle) >= SC) ph = P_IDLE;
            end
            default:  ph = P_IDLE;
        endcase
        if (pop) void'(q.pop_front());
        if (acc) begin
            q.push_back(d);
            t_wr = cyc;
        end
        if (v && !acc) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic compare_outputs();
        bit ev;
        ev = (ph == P_BURST) && (q.size() != 0);
        chk("aux",       32'(bus.aux),       32'(ph == P_IDLE));
        chk("out_valid", 32'(bus.out_valid), 32'(ev));
        chk("level",     32'(bus.level),     32'(q.size()));
        chk("full",      32'(bus.full),      32'(q.size() == DEPTH));
        chk("overflow",  32'(bus.overflow),  32'(m_ovf));
        if (ev) chk("out_data", 32'(bus.out_data), 32'(q[0]));
    endtask

    // Check the state left by the previous edge, then drive the next inputs
    // and advance the model across the coming edge.
    task automatic drive_cycle(input bit v, input logic [7:0] d, input bit fl, input bit rdy, input bit clr);
        @(negedge clk);
        compare_outputs();
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.flush     = fl;
        bus.out_ready = rdy;
        bus.ovf_clr   = clr;
        m_step(v, d, fl, rdy, clr);
    endtask

    task automatic idle_cycles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00, 1'b0, rdy, 1'b0);
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_aux",       32'(bus.aux),       32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_level",     32'(bus.level),     32'd0);
        chk("rst_full",      32'(bus.full),      32'd0);
        chk("rst_overflow",  32'(bus.overflow),  32'd0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        m_step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2;
        do_reset();
        idle_cycles(2, 1'b1);

        // Threshold start: four bytes, consumer always ready.
        drive_cycle(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
        drive_cycle(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
        drive_cycle(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
        drive_cycle(1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
        idle_cycles(1, 1'b1);
        chk("thr_not_yet_valid", 32'(bus.out_valid), 32'd0);
        idle_cycles(1, 1'b1);
        chk("thr_valid_rise", 32'(bus.out_valid), 32'd1);
        chk("thr_first_byte", 32'(bus.out_data), 32'h11);
        idle_cycles(SC + 8, 1'b1);

        // Idle timeout (or its absence) after two bytes, then a flush.
        drive_cycle(1'b1, 8'hA1, 1'b0, 1'b1, 1'b0);
        drive_cycle(1'b1, 8'hA2, 1'b0, 1'b1, 1'b0);
        idle_cycles(TO + 5, 1'b1);
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        idle_cycles(SC + 6, 1'b1);

        // Overflow and pointer wrap: nine writes with the consumer stalled.
        for (int i = 0; i < 9; i++) drive_cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        idle_cycles(1, 1'b0);
        chk("ovf_full",  32'(bus.full),     32'd1);
        chk("ovf_flag",  32'(bus.overflow), 32'd1);
        chk("ovf_level", 32'(bus.level),    32'(DEPTH));
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        // Write and pop together while full: level holds, no overflow.
        drive_cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        idle_cycles(1, 1'b0);
        chk("wp_level",    32'(bus.level),    32'(DEPTH));
        chk("wp_overflow", 32'(bus.overflow), 32'd0);
        idle_cycles(DEPTH + 2, 1'b1);
        // Write during SETTLE re-enters FILL, then second round across the wrap.
        idle_cycles(2, 1'b1);
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        idle_cycles(2, 1'b0);
        idle_cycles(DEPTH + SC + 4, 1'b1);

        // Reset in the middle of a burst holding five words.
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 8'(8'h51 + i), 1'b0, 1'b0, 1'b0);
        idle_cycles(1, 1'b0);
        @(negedge clk);
        compare_outputs();
        chk("pre_rst_level", 32'(bus.level), 32'd5);
        do_reset();
        drive_cycle(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        idle_cycles(1, 1'b1);
        chk("post_rst_byte",  32'(bus.out_data),  32'hA5);
        chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
        idle_cycles(SC + 4, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            drive_cycle($urandom_range(0, 99) < 40,
                        8'($urandom()),
                        $urandom_range(0, 99) < 3,
                        $urandom_range(0, 99) < 60,
                        $urandom_range(0, 99) < 5);
        end
        idle_cycles(DEPTH + SC + 4, 1'b1);
        @(negedge clk);
        compare_outputs();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
